// File: rtl/rv32_id_ex_decode_stage.sv
// RV32IM decode stage: turns one instruction per transfer into ALU control, operands and
// write-back/memory flags, held in the ID/EX register and squashed after an EX redirect.
module rv32_id_ex_decode_stage #(
  parameter int data_width   = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [data_width-1:0] in_pc,
  input  logic [data_width-1:0] rs1_data,
  input  logic [data_width-1:0] rs2_data,
  input  logic                  ex_redirect,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            alu_ctrl,
  output logic [data_width-1:0] operand_a,
  output logic [data_width-1:0] operand_b,
  output logic [data_width-1:0] ex_imm,
  output logic [data_width-1:0] ex_pc,
  output logic [4:0]            ex_rd,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  is_branch,
  output logic                  is_jump,
  output logic                  is_muldiv,
  output logic                  illegal
);
  localparam logic [0:0] RUN = 1'b0, SQUASH = 1'b1;
  localparam logic [1:0] A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2;
  localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;

  typedef struct packed {
    logic [5:0]            alu;
    logic [data_width-1:0] a, b, imm, pc;
    logic [4:0]            rd;
    logic                  rw, mr, mw, br, jp, md, ill;
  } idex_t;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  idex_t              dec, out_q, out_d;
  logic signed [31:0] imm32;
  logic [1:0]         sel_a, sel_b;
  logic [0:0]         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               vld_q, vld_d;

  always_comb begin
    dec     = '0;
    imm32   = '0;
    sel_a   = A_RS1;
    sel_b   = B_RS2;
    dec.pc  = in_pc;
    dec.rd  = in_instr[11:7];
    case (opc)
      7'b0110011: begin
        dec.rw = 1'b1;
        case (f7)
          7'b0000000:
            case (f3)
              3'b000: dec.alu = 6'b000000;
              3'b001: dec.alu = 6'b000001;
              3'b010: dec.alu = 6'b000010;
              3'b011: dec.alu = 6'b000011;
              3'b100: dec.alu = 6'b000100;
              3'b101: dec.alu = 6'b000101;
              3'b110: dec.alu = 6'b000110;
              default: dec.alu = 6'b000111;
            endcase
          7'b0100000:
            if (f3 == 3'b000)      dec.alu = 6'b001000;
            else if (f3 == 3'b101) dec.alu = 6'b001101;
            else                   dec.ill = 1'b1;
          7'b0000001: dec.md = 1'b1;
          default:    dec.ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec.rw = 1'b1;
        sel_b  = B_IMM;
        imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
        case (f3)
          3'b000: dec.alu = 6'b000000;
          3'b010: dec.alu = 6'b000010;
          3'b011: dec.alu = 6'b000011;
          3'b100: dec.alu = 6'b000100;
          3'b110: dec.alu = 6'b000110;
          3'b111: dec.alu = 6'b000111;
          3'b001: begin
            imm32 = {27'b0, in_instr[24:20]};
            if (f7 == 7'b0000000) dec.alu = 6'b000001;
            else                  dec.ill = 1'b1;
          end
          default: begin
            imm32 = {27'b0, in_instr[24:20]};
            if (f7 == 7'b0000000)      dec.alu = 6'b000101;
            else if (f7 == 7'b0100000) dec.alu = 6'b001101;
            else                       dec.ill = 1'b1;
          end
        endcase
      end
      7'b0000011: begin
        dec.rw = 1'b1;
        dec.mr = 1'b1;
        sel_b  = B_IMM;
        imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0100011: begin
        dec.mw  = 1'b1;
        sel_b   = B_IMM;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec.ill = (f3 > 3'b010);
      end
      7'b1100011: begin
        dec.br = 1'b1;
        imm32  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
        case (f3)
          3'b000:  dec.alu = 6'b010000;
          3'b001:  dec.alu = 6'b010001;
          3'b100:  dec.alu = 6'b000010;
          3'b101:  dec.alu = 6'b010101;
          3'b110:  dec.alu = 6'b010110;
          3'b111:  dec.alu = 6'b010111;
          default: dec.ill = 1'b1;
        endcase
      end
      7'b0110111: begin
        dec.rw = 1'b1;
        sel_a  = A_ZERO;
        sel_b  = B_IMM;
        imm32  = {in_instr[31:12], 12'b0};
      end
      7'b0010111: begin
        dec.rw = 1'b1;
        sel_a  = A_PC;
        sel_b  = B_IMM;
        imm32  = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.rw = 1'b1;
        dec.jp = 1'b1;
        sel_a  = A_PC;
        sel_b  = B_FOUR;
        imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};
      end
      7'b1100111: begin
        dec.rw  = 1'b1;
        dec.jp  = 1'b1;
        dec.alu = 6'b100111;
        sel_b   = B_IMM;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.ill = (f3 != 3'b000);
      end
      default: dec.ill = 1'b1;
    endcase
    dec.imm = data_width'(imm32);
    case (sel_a)
      A_PC:    dec.a = in_pc;
      A_ZERO:  dec.a = '0;
      default: dec.a = rs1_data;
    endcase
    case (sel_b)
      B_IMM:   dec.b = dec.imm;
      B_FOUR:  dec.b = data_width'(32'd4);
      default: dec.b = rs2_data;
    endcase
    // Illegal instructions must never cause side effects downstream.
    if (dec.ill) begin
      dec.alu = '0;
      {dec.rw, dec.mr, dec.mw, dec.br, dec.jp, dec.md} = '0;
    end
    if (dec.rd == 5'd0) dec.rw = 1'b0;
  end

  assign in_ready = !rst && ((state_q == SQUASH) || !vld_q || out_ready);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    out_d   = out_q;
    if (ex_redirect) begin
      vld_d   = 1'b0;
      cnt_d   = 3'(FLUSH_CYCLES);
      state_d = SQUASH;
    end else if (state_q == SQUASH) begin
      if (in_valid) begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = RUN;
      end
    end else if (in_valid && in_ready) begin
      vld_d = 1'b1;
      out_d = dec;
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
    end
  end

  assign out_valid = vld_q;
  assign alu_ctrl  = out_q.alu;
  assign operand_a = out_q.a;
  assign operand_b = out_q.b;
  assign ex_imm    = out_q.imm;
  assign ex_pc     = out_q.pc;
  assign ex_rd     = out_q.rd;
  assign reg_write = out_q.rw;
  assign mem_read  = out_q.mr;
  assign mem_write = out_q.mw;
  assign is_branch = out_q.br;
  assign is_jump   = out_q.jp;
  assign is_muldiv = out_q.md;
  assign illegal   = out_q.ill;
endmodule

// File: tb/tb_rv32_id_ex_decode_stage.sv
// Directed bench for the decode stage: expected ID/EX contents are queued when an
// instruction is offered and checked after the capturing edge.
module tb_rv32_id_ex_decode_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, ex_redirect, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
  logic [5:0]  alu_ctrl;
  logic [31:0] operand_a, operand_b, ex_imm, ex_pc;
  logic [4:0]  ex_rd;
  logic        reg_write, mem_read, mem_write, is_branch, is_jump, is_muldiv, illegal;

  rv32_id_ex_decode_stage #(.data_width(32), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_redirect(ex_redirect),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .operand_a(operand_a), .operand_b(operand_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .is_branch(is_branch), .is_jump(is_jump), .is_muldiv(is_muldiv), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // fl = {rw, mr, mw, br, jp, md, ill}; msk = {check a/b, check imm, check rd}
  typedef struct {
    logic [5:0]  alu;
    logic [31:0] a, b, imm, pc;
    logic [4:0]  rd;
    logic [6:0]  fl;
    logic [2:0]  msk;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input logic [5:0] alu, input logic [31:0] a, b, imm, pc,
                              input logic [4:0] rd, input logic [6:0] fl, input logic [2:0] msk);
    exp_t e;
    e.alu = alu; e.a = a; e.b = b; e.imm = imm; e.pc = pc; e.rd = rd; e.fl = fl; e.msk = msk;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmp_fields(input exp_t e);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("alu_ctrl", 32'(alu_ctrl), 32'(e.alu));
    if (e.msk[2]) begin
      chk("operand_a", operand_a, e.a);
      chk("operand_b", operand_b, e.b);
    end
    if (e.msk[1]) chk("ex_imm", ex_imm, e.imm);
    if (e.msk[0]) chk("ex_rd", 32'(ex_rd), 32'(e.rd));
    chk("ex_pc", ex_pc, e.pc);
    chk("flags", 32'({reg_write, mem_read, mem_write, is_branch, is_jump, is_muldiv, illegal}),
        32'(e.fl));
  endtask

  task automatic check_out();
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_underflow: observed 0 entries expected 1");
    end else begin
      last = sb.pop_front();
      cmp_fields(last);
    end
  endtask

  task automatic send(input logic [31:0] ins, pc, r1, r2, input exp_t e);
    @(negedge clk);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; rs1_data = r1; rs2_data = r2;
    chk("in_ready_send", 32'(in_ready), 32'd1);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ex_redirect = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_alu", 32'(alu_ctrl), 32'd0);
    chk("rst_opa", operand_a, 32'd0);
    chk("rst_flags", 32'({reg_write, mem_read, mem_write, is_branch, is_jump, is_muldiv, illegal}), 32'd0);
    @(negedge clk); rst = 1'b0;

    // ADD x3,x1,x2
    send(32'h002081B3, 32'h100, 32'd5, 32'd7, mk(6'b000000, 5, 7, 0, 32'h100, 3, 7'b1000000, 3'b101));
    check_out();
    // SRAI x4,x1,3 then ADDI x5,x0,-1, back to back
    send(32'h4030D213, 32'h104, 32'h80, 32'h0, mk(6'b001101, 32'h80, 3, 3, 32'h104, 4, 7'b1000000, 3'b111));
    check_out();
    send(32'hFFF00293, 32'h108, 32'h0, 32'h0, mk(6'b000000, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h108, 5, 7'b1000000, 3'b111));
    check_out();
    // BEQ held by EX for three cycles; a waiting ADD must not disturb it
    send(32'h00208463, 32'h10C, 32'd9, 32'd9, mk(6'b010000, 9, 9, 8, 32'h10C, 0, 7'b0001000, 3'b110));
    out_ready = 1'b0;
    check_out();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h110; rs1_data = 32'd1; rs2_data = 32'd2;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      cmp_fields(last);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_drained", 32'(out_valid), 32'd0);

    // JALR x1,0(x5), then redirect with a wrong-path instruction offered
    send(32'h000280E7, 32'h200, 32'h2000, 32'h0, mk(6'b100111, 32'h2000, 0, 0, 32'h200, 1, 7'b1000100, 3'b111));
    check_out();
    @(negedge clk);
    ex_redirect = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h204;
    chk("redir_valid_before", 32'(out_valid), 32'd1);
    chk("redir_alu_before", 32'(alu_ctrl), 32'b100111);
    @(posedge clk); #1;
    ex_redirect = 1'b0; in_valid = 1'b0;
    chk("redir_valid_after", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("squash_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_instr = 32'hFFF00293; in_pc = 32'h208;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("squash_dropped", 32'(out_valid), 32'd0);
    // LUI x7,0x12345 is the first instruction kept after the flush
    send(32'h123453B7, 32'h20C, 32'hDEAD, 32'hBEEF, mk(6'b000000, 0, 32'h12345000, 32'h12345000, 32'h20C, 7, 7'b1000000, 3'b111));
    check_out();

    // Idle cycles during squash must not count toward the flush
    @(negedge clk); ex_redirect = 1'b1;
    @(posedge clk); #1; ex_redirect = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h300; rs1_data = 1; rs2_data = 2;
    @(posedge clk); #1; in_valid = 1'b0;
    chk("squash_idle_hold", 32'(out_valid), 32'd0);
    // SUB x6,x1,x2
    send(32'h40208333, 32'h304, 32'd5, 32'd3, mk(6'b001000, 5, 3, 0, 32'h304, 6, 7'b1000000, 3'b101));
    check_out();

    // Asynchronous reset mid-cycle while squashing
    @(negedge clk); ex_redirect = 1'b1;
    @(posedge clk); #1; ex_redirect = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_alu", 32'(alu_ctrl), 32'd0);
    chk("arst_opa", operand_a, 32'd0);
    chk("arst_rd", 32'(ex_rd), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    send(32'h002081B3, 32'h400, 32'd11, 32'd22, mk(6'b000000, 11, 22, 0, 32'h400, 3, 7'b1000000, 3'b101));
    check_out();

    // Illegal opcode, rd = x0, and remaining formats
    send(32'h0000007F, 32'h500, 32'd1, 32'd2, mk(6'b000000, 0, 0, 0, 32'h500, 0, 7'b0000001, 3'b000));
    check_out();
    send(32'h00208033, 32'h504, 32'd1, 32'd2, mk(6'b000000, 1, 2, 0, 32'h504, 0, 7'b0000000, 3'b101));
    check_out();
    send(32'h0020A623, 32'h508, 32'h1000, 32'h55, mk(6'b000000, 32'h1000, 12, 12, 32'h508, 0, 7'b0010000, 3'b110));
    check_out();
    send(32'hFFC0A483, 32'h50C, 32'h1000, 32'h0, mk(6'b000000, 32'h1000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h50C, 9, 7'b1100000, 3'b111));
    check_out();
    send(32'h02208533, 32'h510, 32'd6, 32'd7, mk(6'b000000, 6, 7, 0, 32'h510, 10, 7'b1000010, 3'b101));
    check_out();
    send(32'h40309213, 32'h514, 32'd1, 32'd0, mk(6'b000000, 0, 0, 0, 32'h514, 0, 7'b0000001, 3'b000));
    check_out();
    send(32'h0020C463, 32'h518, 32'd3, 32'd4, mk(6'b000010, 3, 4, 8, 32'h518, 0, 7'b0001000, 3'b110));
    check_out();
    send(32'h00001417, 32'h600, 32'd9, 32'd9, mk(6'b000000, 32'h600, 32'h1000, 32'h1000, 32'h600, 8, 7'b1000000, 3'b111));
    check_out();
    send(32'h010000EF, 32'h700, 32'd9, 32'd9, mk(6'b000000, 32'h700, 4, 16, 32'h700, 1, 7'b1000100, 3'b111));
    check_out();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32_id_ex_decode_stage.md
Name: rv32_id_ex_decode_stage

Overview:
- Decode-to-execute pipeline stage. Decodes one RV32IM instruction per accepted transfer into the 6-bit ALU control code, operand values and write-back/memory flags consumed by the execute-stage ALU.
- Holds the result in the ID/EX pipeline register behind a valid/ready handshake.
- Consumes the ALU's redirect feedback (hold_pipeline) to squash wrong-path instructions for a fixed number of cycles.

Parameters:
- data_width, 32, operand/PC width
- FLUSH_CYCLES, 1, cycles of upstream instructions discarded after a redirect (1..7)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  stage can accept an instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  data_width  PC of in_instr
- rs1_data  in  data_width  register-file read, port 1 (combinational, indexed by in_instr[19:15])
- rs2_data  in  data_width  register-file read, port 2 (indexed by in_instr[24:20])
- ex_redirect  in  1  ALU hold_pipeline: taken branch or JALR redirect in EX
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX accepts the ID/EX contents
- alu_ctrl  out  6  ALU_Control code
- operand_a  out  data_width  ALU operand A
- operand_b  out  data_width  ALU operand B
- ex_imm  out  data_width  sign-extended immediate
- ex_pc  out  data_width  PC of the instruction
- ex_rd  out  5  destination register
- reg_write  out  1  write-back enable (forced 0 when rd = x0)
- mem_read  out  1  load
- mem_write  out  1  store
- is_branch  out  1  conditional branch
- is_jump  out  1  JAL or JALR
- is_muldiv  out  1  M-extension op, routed to the MUL/DIV unit
- illegal  out  1  undecodable instruction

Behaviour:
- Reset: every output register is 0, state = RUN, flush counter = 0, in_ready = 0 while rst is high.
- ALU code map:
  - 000000: ADD, ADDI, loads, stores, LUI, AUIPC, JAL, M-ops
  - 001000: SUB
  - 000110: OR/ORI
  - 000100: XOR/XORI
  - 000111: AND/ANDI
  - 000001: SLL/SLLI
  - 000101: SRL/SRLI
  - 001101: SRA/SRAI
  - 000010: SLT/SLTI and BLT; is_branch distinguishes them
  - 000011: SLTU/SLTIU
  - 100111: JALR
  - 010000: BEQ
  - 010001: BNE
  - 010101: BGE
  - 010110: BLTU
  - 010111: BGEU
- Operands:
  - R-type and branches: a = rs1, b = rs2
  - I-type, load, store, JALR: a = rs1, b = imm
  - LUI: a = 0, b = imm
  - AUIPC: a = pc, b = imm
  - JAL: a = pc, b = 4
- Immediates: I/S/B/U/J formats, sign-extended to data_width; shift immediates use instr[24:20].
- Illegal: unknown opcode/funct3/funct7 (including SLLI/SRLI with funct7 ≠ 0000000). Registered with out_valid = 1, illegal = 1, alu_ctrl = 000000, reg_write = mem_read = mem_write = 0.
- Latency: 1 cycle. An instruction accepted at edge N is presented on the outputs after edge N.
- Handshake:
  - Transfer on in_valid & in_ready.
  - in_ready = !out_valid | out_ready (also 1 in SQUASH).
  - The output register holds all fields stable while out_valid & !out_ready.
- State machine RUN / SQUASH:
  - RUN: normal operation.
  - ex_redirect = 1 in any state, at the edge: out_valid := 0, the same-cycle input transfer is discarded, counter := FLUSH_CYCLES, state := SQUASH.
  - SQUASH: in_ready = 1. Each cycle with in_valid = 1 discards that instruction and decrements the counter. At counter = 1 with a discard, state := RUN.
  - In SQUASH, cycles with in_valid = 0 do not decrement the counter.
- Priority: rst > ex_redirect > transfer. A redirect received during SQUASH reloads the counter.
- A reset asserted mid-operation clears state immediately, without waiting for a clock edge.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1 = 5, rs2 = 7 → next cycle: out_valid = 1, alu_ctrl = 000000, a = 5, b = 7, ex_rd = 3, reg_write = 1.
- SRAI x4,x1,3 (0x4030D213) then ADDI x5,x0,-1 (0xFFF00293) → first: alu_ctrl = 001101, b = 3. Second: alu_ctrl = 000000, b = 0xFFFFFFFF, ex_imm = 0xFFFFFFFF.
- BEQ x1,x2,+8 (0x00208463) held with out_ready = 0 for 3 cycles → alu_ctrl = 010000, is_branch = 1, ex_imm = 8, all fields stable; in_ready = 0 during the hold.
- JALR x1,0(x5) (0x000280E7) accepted; next cycle ex_redirect = 1 with in_valid = 1 → alu_ctrl = 100111 observed; then out_valid = 0. With FLUSH_CYCLES = 1, exactly one following instruction is dropped and the next one is registered.
- Opcode 0x0000007F → out_valid = 1, illegal = 1, reg_write = 0. ADD with rd = x0 → reg_write = 0.
- rst pulsed asynchronously between edges during SQUASH → outputs 0 immediately; state = RUN after release; next ADD is accepted normally.
